rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl_pkg.sv | 30 +++
 rtl/rst_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// Shared configuration for the reset sequencer: state encoding, default
// parameter values and width helpers used by the sequencer and its users.
package rst_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_NUM_DOM  = 2;
  localparam int unsigned DEF_HOLD_CYC = 4;
  localparam int unsigned DEF_TMO_CYC  = 64;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of a domain index; a single domain still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shared hold/timeout counter width; both limits count 0..LIMIT-1.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned tmo);
    return $clog2(max_u(hold, tmo));
  endfunction

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain in reset, then releases the domains
// one at a time in index order, waiting for each to report its synchronized
// release before moving on. Reports RUN, or ERR with the failing domain.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DOM  = DEF_NUM_DOM,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned TMO_CYC  = DEF_TMO_CYC
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              SW_RST_REQ,
  input  logic [NUM_DOM-1:0]                DOM_DONE,
  output logic [NUM_DOM-1:0]                DOM_RST_N,
  output logic                              SEQ_BUSY,
  output logic                              SEQ_DONE,
  output logic                              SEQ_ERR,
  output logic [idx_width(NUM_DOM)-1:0]     ERR_DOM
);

  localparam int unsigned IDX_W = idx_width(NUM_DOM);
  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, TMO_CYC);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               seq_busy_q, seq_busy_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_err_q, seq_err_d;
  logic [IDX_W-1:0]   err_dom_q, err_dom_d;

  logic               cur_done;
  logic [NUM_DOM-1:0] nxt_rel;
  logic               any_fall;
  logic [IDX_W-1:0]   fall_idx;

  // Done status of the domain currently being released; higher bits ignored.
  always_comb begin
    cur_done = 1'b0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_done = DOM_DONE[i];
      end
    end
  end

  // One-hot mask of the domain that follows the current one.
  always_comb begin
    nxt_rel = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (i == 32'(idx_q) + 32'd1) begin
        nxt_rel[i] = 1'b1;
      end
    end
  end

  // Lowest-index domain whose done status has dropped.
  always_comb begin
    any_fall = 1'b0;
    fall_idx = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (!DOM_DONE[i] && !any_fall) begin
        any_fall = 1'b1;
        fall_idx = IDX_W'(i);
      end
    end
  end

  // Next-state and registered-output logic; a software request overrides all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_n_d = dom_rst_n_q;
    err_dom_d   = err_dom_q;

    if (SW_RST_REQ) begin
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      dom_rst_n_d = '0;
      err_dom_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          dom_rst_n_d = '0;
          if (cnt_q == HOLD_LAST) begin
            dom_rst_n_d[0] = 1'b1;
            idx_d          = '0;
            cnt_d          = '0;
            state_d        = ST_WAIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          // A done seen on the last timeout cycle still counts as success.
          if (cur_done) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
            end else begin
              idx_d       = idx_q + 1'b1;
              cnt_d       = '0;
              dom_rst_n_d = dom_rst_n_q | nxt_rel;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_d   = ST_ERR;
            err_dom_d = idx_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (any_fall) begin
            state_d   = ST_ERR;
            err_dom_d = fall_idx;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    seq_busy_d = (state_d == ST_HOLD) || (state_d == ST_WAIT);
    seq_done_d = (state_d == ST_RUN);
    seq_err_d  = (state_d == ST_ERR);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
      seq_busy_q  <= 1'b1;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_dom_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
      err_dom_q   <= err_dom_d;
    end
  end

  assign DOM_RST_N = dom_rst_n_q;
  assign SEQ_BUSY  = seq_busy_q;
  assign SEQ_DONE  = seq_done_q;
  assign SEQ_ERR   = seq_err_q;
  assign ERR_DOM   = err_dom_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl. Each scenario is a plan of per-domain
// done delays (plus optional RUN-phase drop, software restart or async
// reset); a timeline model turns the plan into DOM_DONE stimulus and the
// expected outputs after every clock edge.
module tb_rst_seq_ctrl;

  localparam int NUM_DOM  = 2;
  localparam int HOLD_CYC = 4;
  localparam int TMO_CYC  = 64;
  localparam int IW       = 1;

  logic               CLK = 1'b0;
  logic               RST;
  logic               SW_RST_REQ;
  logic [NUM_DOM-1:0] DOM_DONE;
  logic [NUM_DOM-1:0] DOM_RST_N;
  logic               SEQ_BUSY;
  logic               SEQ_DONE;
  logic               SEQ_ERR;
  logic [IW-1:0]      ERR_DOM;

  rst_seq_ctrl #(
    .NUM_DOM (NUM_DOM),
    .HOLD_CYC(HOLD_CYC),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_RST_REQ(SW_RST_REQ),
    .DOM_DONE  (DOM_DONE),
    .DOM_RST_N (DOM_RST_N),
    .SEQ_BUSY  (SEQ_BUSY),
    .SEQ_DONE  (SEQ_DONE),
    .SEQ_ERR   (SEQ_ERR),
    .ERR_DOM   (ERR_DOM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NUM_DOM-1:0] rst_n;
    logic               busy;
    logic               done;
    logic               err;
    logic [IW-1:0]      dom;
    bit                 chk_dom;
    int                 scen;
    int                 edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic chk_tgl = 1'b0;

  // Scenario plan and derived timeline (edges counted from scenario start).
  int               d[NUM_DOM];
  int               rel[NUM_DOM];
  int               run_e, err_e, err_ix, drop_off, drop_at, nat_len, noise_mode;
  logic [NUM_DOM-1:0] drop_mask;
  int               scen_id = 0;

  // Release edge of each domain, RUN edge, ERR edge and failing index.
  function automatic void plan();
    int r;
    r = HOLD_CYC;
    run_e = -1; err_e = -1; err_ix = 0; drop_at = -1;
    for (int k = 0; k < NUM_DOM; k++) rel[k] = -1;
    for (int k = 0; k < NUM_DOM; k++) begin
      rel[k] = r;
      if (d[k] > TMO_CYC) begin
        err_e  = r + TMO_CYC;
        err_ix = k;
        break;
      end
      r += d[k];
    end
    if (err_e < 0) begin
      run_e = r;
      if (drop_off > 0) begin
        drop_at = run_e + drop_off;
        err_e   = drop_at;
        for (int k = NUM_DOM - 1; k >= 0; k--) if (drop_mask[k]) err_ix = k;
      end
    end
    nat_len = ((err_e >= 0) ? err_e : run_e) + 3;
  endfunction

  // DOM_DONE value sampled at edge e: noise until a domain is being waited on.
  function automatic logic [NUM_DOM-1:0] din_at(input int e);
    logic [NUM_DOM-1:0] v;
    for (int k = 0; k < NUM_DOM; k++) begin
      if (rel[k] < 0 || e <= rel[k])
        v[k] = (noise_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (e < rel[k] + d[k])
        v[k] = 1'b0;
      else if (drop_at >= 0 && e >= drop_at && drop_mask[k])
        v[k] = 1'b0;
      else
        v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic exp_t exp_at(input int e);
    exp_t x;
    x.scen = scen_id; x.edge_n = e; x.chk_dom = 1'b0; x.dom = '0;
    for (int k = 0; k < NUM_DOM; k++) x.rst_n[k] = (rel[k] >= 0 && e >= rel[k]);
    x.busy = 1'b0; x.done = 1'b0; x.err = 1'b0;
    if (err_e >= 0 && e >= err_e) begin
      x.err = 1'b1; x.dom = IW'(err_ix); x.chk_dom = 1'b1;
    end else if (run_e >= 0 && e >= run_e) begin
      x.done = 1'b1;
    end else begin
      x.busy = 1'b1;
    end
    return x;
  endfunction

  function automatic exp_t hold_exp(input int e, input bit with_dom);
    exp_t x;
    x.scen = scen_id; x.edge_n = e; x.rst_n = '0;
    x.busy = 1'b1; x.done = 1'b0; x.err = 1'b0;
    x.dom = '0; x.chk_dom = with_dom;
    return x;
  endfunction

  // sw_e: -1 restart after the natural end, -2 random restart point, >0 fixed
  // restart edge. rst_e > 0: async reset after that edge instead of a restart.
  task automatic run_scen(input int d0, input int d1, input int doff,
                          input logic [NUM_DOM-1:0] dmask, input int sw_e,
                          input int nmode, input int rst_e);
    int last;
    d[0] = d0; d[1] = d1; drop_off = doff; drop_mask = dmask; noise_mode = nmode;
    plan();
    scen_id++;
    if (sw_e == -2) sw_e = int'($urandom_range(1, nat_len));
    last = (rst_e > 0) ? rst_e : ((sw_e > 0) ? sw_e : nat_len);
    for (int e = 1; e <= last; e++) begin
      DOM_DONE   = din_at(e);
      SW_RST_REQ = (rst_e <= 0 && e == last);
      @(posedge CLK);
      if (rst_e <= 0 && e == last) exp_q.push_back(hold_exp(e, 1'b0));
      else                         exp_q.push_back(exp_at(e));
      #1;
    end
    SW_RST_REQ = 1'b0;
    if (rst_e > 0) begin
      #6;
      RST = 1'b0;
      #1;
      exp_q.push_back(hold_exp(-1, 1'b1));
      chk_tgl = ~chk_tgl;
      repeat (3) begin
        @(posedge CLK);
        exp_q.push_back(hold_exp(-2, 1'b1));
      end
      #3;
      RST = 1'b1;
    end
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(TMO_CYC - 1, TMO_CYC + 2));
    return int'($urandom_range(1, 12));
  endfunction

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge CLK or chk_tgl);
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_vec++;
        if (x.rst_n !== DOM_RST_N || x.busy !== SEQ_BUSY || x.done !== SEQ_DONE ||
            x.err !== SEQ_ERR || (x.chk_dom && x.dom !== ERR_DOM)) begin
          n_miss++;
          $display("FAIL out_vec scen=%0d edge=%0d actual rst_n=%b busy=%b done=%b err=%b dom=%0d required rst_n=%b busy=%b done=%b err=%b dom=%0d",
                   x.scen, x.edge_n, DOM_RST_N, SEQ_BUSY, SEQ_DONE, SEQ_ERR, ERR_DOM,
                   x.rst_n, x.busy, x.done, x.err, x.dom);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached, queue=%0d", exp_q.size());
    $fatal(1);
  end

  // Stimulus: reset, directed scenarios, async reset mid-WAIT, random scenarios.
  initial begin
    RST = 1'b0; SW_RST_REQ = 1'b0; DOM_DONE = '0;
    #1;
    exp_q.push_back(hold_exp(-1, 1'b1));
    @(posedge CLK);
    exp_q.push_back(hold_exp(-2, 1'b1));
    @(posedge CLK);
    #3;
    RST = 1'b1;

    run_scen(3, 3, 0, '0, -1, 0, 0);                 // nominal release order
    run_scen(3, TMO_CYC + 1, 0, '0, -1, 0, 0);       // domain 1 times out
    run_scen(2, 5, 3, 2'b11, -1, 0, 0);              // RUN drop, both bits
    run_scen(3, 4, 0, '0, HOLD_CYC + 3, 0, 0);       // restart with done
    run_scen(3, 4, 0, '0, -1, 0, 0);                 // full repeat
    run_scen(10, 2, 0, '0, -1, 1, 0);                // early high bit ignored
    run_scen(TMO_CYC, 1, 0, '0, -1, 0, 0);           // done on last count
    run_scen(1, TMO_CYC, 0, '0, -1, 0, 0);
    run_scen(TMO_CYC + 1, 1, 0, '0, -1, 0, 0);       // domain 0 times out
    run_scen(2, 2, 1, 2'b10, -1, 0, 0);              // RUN drop, bit 1 only
    run_scen(5, 5, 0, '0, 2, 0, 0);                  // restart during HOLD
    run_scen(20, 3, 0, '0, -1, 0, HOLD_CYC + 5);     // async reset mid-WAIT
    run_scen(4, 6, 0, '0, -1, 0, 0);

    for (int s = 0; s < 24; s++) begin
      int a, b, o, sw;
      logic [NUM_DOM-1:0] m;
      a  = pick_delay();
      b  = pick_delay();
      o  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0;
      m  = NUM_DOM'($urandom_range(1, 3));
      sw = ($urandom_range(0, 3) == 0) ? -2 : -1;
      run_scen(a, b, o, m, sw, 0, 0);
    end

    repeat (2) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
